// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Sequencer state: running normally, or frozen on an outstanding memory access.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Register $0 is hard-wired to zero, so it never carries a real dependency.
    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         DEFAULT_CNT_W = 16;

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sat_counter
// Brief    : Saturating up-counter used for hazard performance statistics.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_sat_counter
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Count enabled cycles; stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule : hazard_sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage pipeline: load-use stalls,
//            taken-branch flushes, memory-wait freeze and hazard counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MemRead_IDEX_i,
    input  logic [4:0]       RTaddr_IDEX_i,
    input  logic [4:0]       RSaddr_IFID_i,
    input  logic [4:0]       RTaddr_IFID_i,
    input  logic             UseRT_IFID_i,
    input  logic             Branch_taken_i,
    input  logic             mem_access_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_flush_o,
    output logic             freeze_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] ldstall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o
);

    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             freeze;
    logic             load_use;
    logic             ldstall_evt;
    logic             flush_evt;

    // Freeze is Mealy: an ack in the same cycle lets the pipeline advance at once.
    assign freeze   = mem_access_i & ~dmem_ack_i;
    assign load_use = MemRead_IDEX_i && (RTaddr_IDEX_i != REG_ZERO) &&
                      ((RTaddr_IDEX_i == RSaddr_IFID_i) ||
                       (UseRT_IFID_i && (RTaddr_IDEX_i == RTaddr_IFID_i)));

    assign flush_evt   = Branch_taken_i & ~freeze;
    assign ldstall_evt = load_use & ~Branch_taken_i & ~freeze;

    // State register; reset aborts any outstanding wait.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and pipeline control decode (freeze > branch > load-use).
    always_comb begin
        state_nxt    = state;
        dmem_req_o   = mem_access_i;
        PC_write_o   = 1'b1;
        IFID_write_o = 1'b1;
        IFID_flush_o = 1'b0;
        IDEX_flush_o = 1'b0;
        freeze_o     = 1'b0;

        case (state)
            RUN:      if (mem_access_i && !dmem_ack_i) state_nxt = MEM_WAIT;
            MEM_WAIT: if (dmem_ack_i)                  state_nxt = RUN;
            default:                                   state_nxt = RUN;
        endcase

        if (freeze) begin
            freeze_o     = 1'b1;
            PC_write_o   = 1'b0;
            IFID_write_o = 1'b0;
        end else if (Branch_taken_i) begin
            IFID_flush_o = 1'b1;
            IDEX_flush_o = 1'b1;
        end else if (load_use) begin
            PC_write_o   = 1'b0;
            IFID_write_o = 1'b0;
            IDEX_flush_o = 1'b1;
        end
    end

    // Wait-cycle counter and sticky timeout flag; counter restarts on each new wait.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt  <= '0;
            mem_err_o <= 1'b0;
        end else if (state == RUN) begin
            wait_cnt <= '0;
        end else if (!dmem_ack_i) begin
            if (wait_cnt != TIMEOUT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_cnt == TIMEOUT_M1) begin
                mem_err_o <= 1'b1;
            end
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_ldstall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ldstall_evt),
        .cnt_o (ldstall_cnt_o)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_evt),
        .cnt_o (flush_cnt_o)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (freeze),
        .cnt_o (memwait_cnt_o)
    );

endmodule : pipeline_hazard_ctrl
`default_nettype wire
